// File: rtl/vram_port_arbiter.sv
// vram_port_arbiter: round-robin, burst-bounded sharing of the LcdVga video-RAM port between requesters A and B
//   clk, reset (async, active-low), frame_int (vblank pulse, forces next round to A)
//   req_x/we_x/addr_x/wdata_x -> gnt_x (registered grant), rdata_x/rvalid_x (routed read return), x in {a,b}
//   ram_ce/ram_wre/ram_ad/ram_din (registered RAM command), ram_dout (RAM read data, RD_LAT after ram_ce)
module vram_port_arbiter #(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 8,
    parameter int RD_LAT    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_int,
    input  logic              req_a,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] wdata_a,
    output logic              gnt_a,
    output logic [DATA_W-1:0] rdata_a,
    output logic              rvalid_a,
    input  logic              req_b,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              gnt_b,
    output logic [DATA_W-1:0] rdata_b,
    output logic              rvalid_b,
    output logic              ram_ce,
    output logic              ram_wre,
    output logic [ADDR_W-1:0] ram_ad,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

    state_t            state, nxt;
    logic              rr_b;
    logic [CW-1:0]     burst_cnt;
    logic              cmd_b;
    logic [RD_LAT-1:0] tag_v, tag_b;
    logic              acc_a, acc_b, acc, own_b, req_x, req_o, last, leave;

    assign acc_a = req_a & gnt_a;
    assign acc_b = req_b & gnt_b;
    assign acc   = acc_a | acc_b;
    assign own_b = (state == OWN_B);
    assign req_x = own_b ? req_b : req_a;
    assign req_o = own_b ? req_a : req_b;
    assign last  = acc && (burst_cnt == CW'(MAX_BURST - 1)) && req_o;

    // A burst-limit handover passes through IDLE so every owner change has one
    // dead cycle; IDLE then picks the other side via rr_b (or A after frame_int).
    assign nxt = (state == IDLE) ? (!(req_a || req_b) ? IDLE :
                                    (req_b && (!req_a || rr_b)) ? OWN_B : OWN_A) :
                 (!req_x && req_o) ? (own_b ? OWN_A : OWN_B) :
                 (last || !req_x)  ? IDLE : (own_b ? OWN_B : OWN_A);
    assign leave = (state != IDLE) && (nxt != state);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            gnt_a     <= 1'b0;
            gnt_b     <= 1'b0;
            rr_b      <= 1'b0;
            burst_cnt <= '0;
        end else begin
            state     <= nxt;
            gnt_a     <= (nxt == OWN_A);
            gnt_b     <= (nxt == OWN_B);
            burst_cnt <= leave ? '0 :
                         (acc && burst_cnt != CW'(MAX_BURST - 1)) ? burst_cnt + 1'b1 : burst_cnt;
            rr_b      <= frame_int ? 1'b0 : leave ? !own_b : rr_b;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ram_ce   <= 1'b0;
            ram_wre  <= 1'b0;
            ram_ad   <= '0;
            ram_din  <= '0;
            cmd_b    <= 1'b0;
            tag_v    <= '0;
            tag_b    <= '0;
            rvalid_a <= 1'b0;
            rvalid_b <= 1'b0;
            rdata_a  <= '0;
            rdata_b  <= '0;
        end else begin
            ram_ce  <= acc;
            ram_wre <= acc & (acc_b ? we_b : we_a);
            if (acc) begin
                ram_ad  <= acc_b ? addr_b : addr_a;
                ram_din <= acc_b ? wdata_b : wdata_a;
                cmd_b   <= acc_b;
            end
            // tag_*[RD_LAT-1] lines up with ram_dout of the read issued RD_LAT cycles ago
            tag_v    <= RD_LAT'({tag_v, ram_ce & ~ram_wre});
            tag_b    <= RD_LAT'({tag_b, cmd_b});
            rvalid_a <= tag_v[RD_LAT-1] & ~tag_b[RD_LAT-1];
            rvalid_b <= tag_v[RD_LAT-1] & tag_b[RD_LAT-1];
            if (tag_v[RD_LAT-1] && !tag_b[RD_LAT-1]) rdata_a <= ram_dout;
            if (tag_v[RD_LAT-1] && tag_b[RD_LAT-1])  rdata_b <= ram_dout;
        end
    end
endmodule

// File: tb/tb_vram_port_arbiter.sv
// tb_vram_port_arbiter: directed and randomized checks of vram_port_arbiter against a RAM model and scoreboard
module tb_vram_port_arbiter;
    localparam int ADDR_W = 12, DATA_W = 16, MAX_BURST = 8, RD_LAT = 1;

    logic clk = 1'b0, reset = 1'b0, frame_int = 1'b0;
    logic req_a = 1'b0, we_a = 1'b0, req_b = 1'b0, we_b = 1'b0;
    logic [ADDR_W-1:0] addr_a = '0, addr_b = '0;
    logic [DATA_W-1:0] wdata_a = '0, wdata_b = '0;
    logic gnt_a, gnt_b, rvalid_a, rvalid_b, ram_ce, ram_wre;
    logic [DATA_W-1:0] rdata_a, rdata_b, ram_din, ram_dout;
    logic [ADDR_W-1:0] ram_ad;
    int npass = 0, ntotal = 0;

    vram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .reset(reset), .frame_int(frame_int),
        .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
        .gnt_a(gnt_a), .rdata_a(rdata_a), .rvalid_a(rvalid_a),
        .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
        .gnt_b(gnt_b), .rdata_b(rdata_b), .rvalid_b(rvalid_b),
        .ram_ce(ram_ce), .ram_wre(ram_wre), .ram_ad(ram_ad), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] init_word(input logic [ADDR_W-1:0] a);
        return {4'h0, a} ^ 16'h5A5A;
    endfunction

    // RAM contents are stored XOR the initial pattern so the zero-initialised array reads as mem[a]=a^0x5A5A
    bit   [DATA_W-1:0] mem [1 << ADDR_W];
    logic [DATA_W-1:0] rpipe [RD_LAT];
    always @(posedge clk) begin
        if (ram_ce && ram_wre) mem[ram_ad] <= ram_din ^ init_word(ram_ad);
        rpipe[0] <= (ram_ce && !ram_wre) ? (mem[ram_ad] ^ init_word(ram_ad)) : rpipe[0];
        for (int i = 1; i < RD_LAT; i++) rpipe[i] <= rpipe[i-1];
    end
    assign ram_dout = rpipe[RD_LAT-1];

    task automatic do_access(input bit side, input bit we, input logic [ADDR_W-1:0] a,
                             input logic [DATA_W-1:0] d, output bit ok);
        ok = 1'b0;
        if (side) begin req_b = 1'b1; we_b = we; addr_b = a; wdata_b = d; end
        else      begin req_a = 1'b1; we_a = we; addr_a = a; wdata_a = d; end
        for (int i = 0; i < 20; i++) begin
            if (side ? gnt_b : gnt_a) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        @(negedge clk);
        req_a = 1'b0;
        req_b = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0; req_a = 1'b1; req_b = 1'b1; we_a = 1'b1; we_b = 1'b1;
        repeat (3) @(negedge clk);
        ntotal++; if ({gnt_a, gnt_b} !== 2'b00) $display("FAIL reset_gnt got %b want 00", {gnt_a, gnt_b}); else npass++;
        ntotal++; if ({ram_ce, ram_wre, rvalid_a, rvalid_b} !== 4'b0) $display("FAIL reset_strobes got %b want 0000", {ram_ce, ram_wre, rvalid_a, rvalid_b}); else npass++;
        ntotal++; if ({ram_ad, ram_din, rdata_a, rdata_b} !== '0) $display("FAIL reset_data got %h/%h/%h/%h want 0", ram_ad, ram_din, rdata_a, rdata_b); else npass++;
        reset = 1'b1;
        @(negedge clk);
        ntotal++; if ({gnt_a, gnt_b} !== 2'b10) $display("FAIL reset_first_grant got %b want 10", {gnt_a, gnt_b}); else npass++;
        req_a = 1'b0; req_b = 1'b0; we_a = 1'b0; we_b = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_write;
        bit ok, seen;
        do_access(1'b1, 1'b1, 12'h123, 16'hF800, ok);
        ntotal++; if (!ok) $display("FAIL write_grant_timeout got 0 want 1"); else npass++;
        ntotal++; if ({ram_ce, ram_wre, ram_ad, ram_din} !== {2'b11, 12'h123, 16'hF800})
            $display("FAIL write_cmd got ce=%b wre=%b ad=%h din=%h want 1 1 123 f800", ram_ce, ram_wre, ram_ad, ram_din); else npass++;
        @(negedge clk);
        ntotal++; if ({ram_ce, ram_wre, ram_ad, ram_din} !== {2'b00, 12'h123, 16'hF800})
            $display("FAIL write_hold got ce=%b wre=%b ad=%h din=%h want 0 0 123 f800", ram_ce, ram_wre, ram_ad, ram_din); else npass++;
        seen = 1'b0;
        repeat (4) begin seen |= rvalid_a | rvalid_b; @(negedge clk); end
        ntotal++; if (seen !== 1'b0) $display("FAIL write_no_rvalid got 1 want 0"); else npass++;
    endtask

    task automatic test_burst_fairness;
        int p;
        bit exp_ce;
        req_a = 1'b1; req_b = 1'b1; we_a = 1'b1; we_b = 1'b1;
        for (int i = 0; i < 36; i++) begin
            @(negedge clk);
            p = i % (2 * MAX_BURST + 2);
            exp_ce = (i > 0) && ((i - 1) % (2 * MAX_BURST + 2) != MAX_BURST) && ((i - 1) % (2 * MAX_BURST + 2) != 2 * MAX_BURST + 1);
            ntotal++; if ({gnt_a, gnt_b} !== {p < MAX_BURST, p > MAX_BURST && p <= 2 * MAX_BURST})
                $display("FAIL burst_grant cycle %0d got %b want %b", i, {gnt_a, gnt_b}, {p < MAX_BURST, p > MAX_BURST && p <= 2 * MAX_BURST}); else npass++;
            ntotal++; if (ram_ce !== exp_ce) $display("FAIL burst_ce cycle %0d got %b want %b", i, ram_ce, exp_ce); else npass++;
            addr_a = 12'h800 | 12'($urandom_range(0, 255)); wdata_a = 16'($urandom);
            addr_b = 12'h900 | 12'($urandom_range(0, 255)); wdata_b = 16'($urandom);
        end
        req_a = 1'b0; req_b = 1'b0; we_a = 1'b0; we_b = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_read_routing;
        bit ok;
        do_access(1'b0, 1'b0, 12'h010, 16'h0, ok);
        ntotal++; if (!ok || {ram_ce, ram_wre, ram_ad} !== {2'b10, 12'h010}) $display("FAIL read_a_cmd got ok=%b ce=%b wre=%b ad=%h want 1 1 0 010", ok, ram_ce, ram_wre, ram_ad); else npass++;
        for (int t = 1; t <= 5; t++) begin
            @(negedge clk);
            ntotal++; if ({rvalid_a, rvalid_b} !== {t == RD_LAT + 1, 1'b0}) $display("FAIL read_a_rvalid t=%0d got %b want %b", t, {rvalid_a, rvalid_b}, {t == RD_LAT + 1, 1'b0}); else npass++;
            if (t == RD_LAT + 1) begin
                ntotal++; if (rdata_a !== init_word(12'h010)) $display("FAIL read_a_data got %h want %h", rdata_a, init_word(12'h010)); else npass++;
            end
        end
        do_access(1'b1, 1'b0, 12'h020, 16'h0, ok);
        ntotal++; if (!ok || {ram_ce, ram_wre, ram_ad} !== {2'b10, 12'h020}) $display("FAIL read_b_cmd got ok=%b ce=%b wre=%b ad=%h want 1 1 0 020", ok, ram_ce, ram_wre, ram_ad); else npass++;
        for (int t = 1; t <= 5; t++) begin
            @(negedge clk);
            ntotal++; if ({rvalid_a, rvalid_b} !== {1'b0, t == RD_LAT + 1}) $display("FAIL read_b_rvalid t=%0d got %b want %b", t, {rvalid_a, rvalid_b}, {1'b0, t == RD_LAT + 1}); else npass++;
            if (t == RD_LAT + 1) begin
                ntotal++; if (rdata_b !== init_word(12'h020)) $display("FAIL read_b_data got %h want %h", rdata_b, init_word(12'h020)); else npass++;
            end
        end
        ntotal++; if (rdata_a !== init_word(12'h010)) $display("FAIL read_a_hold got %h want %h", rdata_a, init_word(12'h010)); else npass++;
    endtask

    task automatic test_frame_priority;
        bit ok;
        req_a = 1'b1; req_b = 1'b1; @(negedge clk);
        ntotal++; if ({gnt_a, gnt_b} !== 2'b10) $display("FAIL frame_after_b got %b want 10", {gnt_a, gnt_b}); else npass++;
        req_a = 1'b0; req_b = 1'b0; repeat (2) @(negedge clk);
        do_access(1'b0, 1'b0, 12'h030, 16'h0, ok); repeat (2) @(negedge clk);
        req_a = 1'b1; req_b = 1'b1; @(negedge clk);
        ntotal++; if (!ok || {gnt_a, gnt_b} !== 2'b01) $display("FAIL frame_rr_no_pulse got ok=%b gnt=%b want 1 01", ok, {gnt_a, gnt_b}); else npass++;
        req_a = 1'b0; req_b = 1'b0; repeat (2) @(negedge clk);
        do_access(1'b0, 1'b0, 12'h031, 16'h0, ok); repeat (2) @(negedge clk);
        frame_int = 1'b1; @(negedge clk); frame_int = 1'b0;
        req_a = 1'b1; req_b = 1'b1; @(negedge clk);
        ntotal++; if (!ok || {gnt_a, gnt_b} !== 2'b10) $display("FAIL frame_idle_pulse got ok=%b gnt=%b want 1 10", ok, {gnt_a, gnt_b}); else npass++;
        req_a = 1'b0; req_b = 1'b0; repeat (2) @(negedge clk);
        do_access(1'b0, 1'b0, 12'h032, 16'h0, ok);
        frame_int = 1'b1; @(negedge clk); frame_int = 1'b0;
        req_a = 1'b1; req_b = 1'b1; @(negedge clk);
        ntotal++; if (!ok || {gnt_a, gnt_b} !== 2'b10) $display("FAIL frame_on_leave got ok=%b gnt=%b want 1 10", ok, {gnt_a, gnt_b}); else npass++;
        req_a = 1'b0; req_b = 1'b0; repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid_read;
        bit ok, seen;
        do_access(1'b0, 1'b0, 12'h040, 16'h0, ok);
        ntotal++; if (!ok || {ram_ce, ram_wre} !== 2'b10) $display("FAIL rstrd_issue got ok=%b ce=%b wre=%b want 1 1 0", ok, ram_ce, ram_wre); else npass++;
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        repeat (3) begin @(negedge clk); seen |= rvalid_a | rvalid_b; end
        ntotal++; if ({gnt_a, gnt_b, ram_ce, ram_wre, ram_ad, ram_din, rdata_a, rdata_b} !== '0)
            $display("FAIL rstrd_outputs got gnt=%b ce=%b wre=%b ad=%h din=%h ra=%h rb=%h want 0", {gnt_a, gnt_b}, ram_ce, ram_wre, ram_ad, ram_din, rdata_a, rdata_b); else npass++;
        reset = 1'b1;
        repeat (4) begin @(negedge clk); seen |= rvalid_a | rvalid_b; end
        ntotal++; if (seen !== 1'b0) $display("FAIL rstrd_dropped got rvalid seen=1 want 0"); else npass++;
        ntotal++; if ({gnt_a, gnt_b} !== 2'b00) $display("FAIL rstrd_idle got %b want 00", {gnt_a, gnt_b}); else npass++;
    endtask

    task automatic test_random;
        localparam int N = 3000;
        bit [DATA_W-1:0]   ref_mem [256];
        int                q_due [$];
        bit                q_own [$];
        logic [DATA_W-1:0] q_dat [$];
        bit pend = 1'b0, pw = 1'b0, va, vb, aa, ab;
        logic [ADDR_W-1:0] pa = '0, last_ad = '0;
        logic [DATA_W-1:0] pd = '0, last_din = '0, exp_ra = '0, exp_rb = '0;
        int ra = 0, rb = 0, sa = 0, sb = 0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(12'(i));
        for (int c = 0; c < N; c++) begin
            @(negedge clk);
            ntotal++; if ({ram_ce, ram_wre, ram_ad, ram_din} !== {pend, pend & pw, pend ? pa : last_ad, pend ? pd : last_din})
                $display("FAIL rnd_cmd cycle %0d got %b %b %h %h want %b %b %h %h", c, ram_ce, ram_wre, ram_ad, ram_din,
                         pend, pend & pw, pend ? pa : last_ad, pend ? pd : last_din); else npass++;
            if (pend) begin last_ad = pa; last_din = pd; end
            va = 1'b0; vb = 1'b0;
            if (q_due.size() > 0 && q_due[0] == c) begin
                va = !q_own[0]; vb = q_own[0];
                if (q_own[0]) exp_rb = q_dat[0]; else exp_ra = q_dat[0];
                void'(q_due.pop_front()); void'(q_own.pop_front()); void'(q_dat.pop_front());
            end
            ntotal++; if ({rvalid_a, rvalid_b, rdata_a, rdata_b} !== {va, vb, exp_ra, exp_rb})
                $display("FAIL rnd_read cycle %0d got %b %b %h %h want %b %b %h %h", c, rvalid_a, rvalid_b, rdata_a, rdata_b, va, vb, exp_ra, exp_rb); else npass++;
            ntotal++; if (gnt_a && gnt_b) $display("FAIL rnd_both_gnt cycle %0d got 11 want not both", c); else npass++;
            if (c < N - 12) begin
                if ($urandom_range(0, 7) == 0) req_a = !req_a;
                if ($urandom_range(0, 7) == 0) req_b = !req_b;
            end else begin
                req_a = 1'b0; req_b = 1'b0;
            end
            we_a = 1'($urandom); addr_a = 12'($urandom_range(0, 31)); wdata_a = 16'($urandom);
            we_b = 1'($urandom); addr_b = 12'($urandom_range(0, 31)); wdata_b = 16'($urandom);
            frame_int = (c % 200 == 199);
            aa = req_a & gnt_a;
            ab = req_b & gnt_b;
            ra = !(gnt_a && req_b) ? 0 : aa ? ra + 1 : ra;
            rb = !(gnt_b && req_a) ? 0 : ab ? rb + 1 : rb;
            sa = (req_a && !gnt_a) ? sa + 1 : 0;
            sb = (req_b && !gnt_b) ? sb + 1 : 0;
            ntotal++; if (ra > MAX_BURST || rb > MAX_BURST) $display("FAIL rnd_burst_bound cycle %0d got %0d/%0d want <=%0d", c, ra, rb, MAX_BURST); else npass++;
            ntotal++; if (sa > 3 * (MAX_BURST + 2) || sb > 3 * (MAX_BURST + 2)) $display("FAIL rnd_starve cycle %0d got %0d/%0d want <=%0d", c, sa, sb, 3 * (MAX_BURST + 2)); else npass++;
            pend = aa | ab;
            if (pend) begin
                pw = ab ? we_b : we_a;
                pa = ab ? addr_b : addr_a;
                pd = ab ? wdata_b : wdata_a;
                if (pw) ref_mem[pa[7:0]] = pd;
                else begin q_due.push_back(c + RD_LAT + 2); q_own.push_back(ab); q_dat.push_back(ref_mem[pa[7:0]]); end
            end
        end
        frame_int = 1'b0;
        ntotal++; if (q_due.size() != 0) $display("FAIL rnd_drain got %0d pending want 0", q_due.size()); else npass++;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_burst_fairness();
        test_read_routing();
        test_frame_priority();
        test_reset_mid_read();
        test_random();
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end
endmodule
